// File: rtl/csr_bank_pkg.sv
// Shared types and constants for the machine-mode CSR bank.
package csr_bank_pkg;

    // CSR read-modify-write operation from the decode unit
    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpWrite = 2'b01,
        OpSet   = 2'b10,
        OpClear = 2'b11
    } csrOperation_e;

    // Encodings match the privileged-architecture MPP field
    typedef enum logic [1:0] {
        PrivUser    = 2'b00,
        PrivMachine = 2'b11
    } privilegeLevel_e;

    // Every address the bank knows about, counters included
    typedef enum logic [11:0] {
        CsrMstatus   = 12'h300,
        CsrMisa      = 12'h301,
        CsrMie       = 12'h304,
        CsrMtvec     = 12'h305,
        CsrMscratch  = 12'h340,
        CsrMepc      = 12'h341,
        CsrMcause    = 12'h342,
        CsrMtval     = 12'h343,
        CsrMip       = 12'h344,
        CsrMcycle    = 12'hB00,
        CsrMinstret  = 12'hB02,
        CsrMcycleh   = 12'hB80,
        CsrMinstreth = 12'hB82,
        CsrCycle     = 12'hC00,
        CsrInstret   = 12'hC02,
        CsrCycleh    = 12'hC80,
        CsrInstreth  = 12'hC82,
        CsrMvendorid = 12'hF11,
        CsrMarchid   = 12'hF12,
        CsrMimpid    = 12'hF13,
        CsrMhartid   = 12'hF14
    } csrAddr_e;

    // mstatus field positions
    localparam int unsigned MstatusMieBit  = 3;
    localparam int unsigned MstatusMpieBit = 7;
    localparam int unsigned MstatusMppLo   = 11;
    localparam int unsigned MstatusMppHi   = 12;

    // mie / mip interrupt bit positions
    localparam int unsigned IrqSwBit    = 3;
    localparam int unsigned IrqTimerBit = 7;
    localparam int unsigned IrqExtBit   = 11;

    localparam logic [31:0] MieWritableMask = 32'h0000_0888;
    localparam logic [31:0] AlignMask       = 32'hFFFF_FFFC;

    // New register value for a CSR operation applied to its old value
    function automatic logic [31:0] apply_op(csrOperation_e op, logic [31:0] old_value,
                                             logic [31:0] operand);
        logic [31:0] result;
        unique case (op)
            OpWrite: result = operand;
            OpSet:   result = old_value | operand;
            OpClear: result = old_value & ~operand;
            OpNone:  result = old_value;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_bank_counter64.sv
// 64-bit counter split into two CSR-writable 32-bit halves.
// A write to a half wins over the increment for that half; the other half still takes the carry.
module csr_counter64
    import csr_bank_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [63:0] sum;

    // Full 64-bit add so the low-half wrap carries into the high half
    always_comb begin
        sum  = {hi_q, lo_q} + {63'd0, inc_i};
        lo_d = wr_lo_i ? wdata_i : sum[31:0];
        hi_d = wr_hi_i ? wdata_i : sum[63:32];
    end

    // Counter state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lo_q <= 32'd0;
            hi_q <= 32'd0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_bank.sv
// Machine-mode CSR storage: read mux, masked writes, trap/MRET state and privilege.
// Optional feature macro: CSR_COUNTERS_EN adds mcycle/minstret and their user shadows.
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            read_enable_i,
    input  logic            write_enable_i,
    input  csrOperation_e   operation_i,
    input  logic [11:0]     address_i,
    input  logic [31:0]     data_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic [31:0]     cause_i,
    input  logic [31:0]     pc_i,
    input  logic [31:0]     tval_i,
    input  logic            instret_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic            irq_sw_i,
    output logic [31:0]     rdata_o,
    output logic            illegal_o,
    output privilegeLevel_e privilege_o,
    output logic [31:0]     mtvec_o,
    output logic [31:0]     mepc_o,
    output logic            interrupt_pending_o
);

    // mstatus is held as its three writable fields
    logic            status_mie_q, status_mie_d;
    logic            status_mpie_q, status_mpie_d;
    privilegeLevel_e status_mpp_q, status_mpp_d;
    privilegeLevel_e priv_q, priv_d;

    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic [31:0] mstatus_value;
    logic [31:0] mip_value;
    logic [31:0] csr_value;
    logic        implemented;
    logic [31:0] csr_wdata;
    logic        csr_we;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
`else
    logic        unused_instret;
    assign unused_instret = instret_i;
`endif

    assign mstatus_value = {19'd0, status_mpp_q, 3'd0, status_mpie_q, 3'd0, status_mie_q, 3'd0};
    assign mip_value     = {20'd0, irq_ext_i, 3'd0, irq_timer_i, 3'd0, irq_sw_i, 3'd0};

    // Address decode: selected register value and whether the address exists
    always_comb begin
        csr_value   = 32'd0;
        implemented = 1'b1;
        case (address_i)
            CsrMstatus:   csr_value = mstatus_value;
            CsrMisa:      csr_value = MISA_VALUE;
            CsrMie:       csr_value = mie_q;
            CsrMtvec:     csr_value = mtvec_q;
            CsrMscratch:  csr_value = mscratch_q;
            CsrMepc:      csr_value = mepc_q;
            CsrMcause:    csr_value = mcause_q;
            CsrMtval:     csr_value = mtval_q;
            CsrMip:       csr_value = mip_value;
            CsrMvendorid: csr_value = 32'd0;
            CsrMarchid:   csr_value = 32'd0;
            CsrMimpid:    csr_value = 32'd0;
            CsrMhartid:   csr_value = MHARTID;
`ifdef CSR_COUNTERS_EN
            CsrMcycle,    CsrCycle:    csr_value = mcycle[31:0];
            CsrMcycleh,   CsrCycleh:   csr_value = mcycle[63:32];
            CsrMinstret,  CsrInstret:  csr_value = minstret[31:0];
            CsrMinstreth, CsrInstreth: csr_value = minstret[63:32];
`endif
            default:      implemented = 1'b0;
        endcase
    end

    assign illegal_o = (read_enable_i | write_enable_i) & ~implemented;
    assign rdata_o   = read_enable_i ? csr_value : 32'd0;

    // Trap and MRET take the cycle; a CSR write alongside them is dropped
    assign csr_wdata = apply_op(operation_i, csr_value, data_i);
    assign csr_we    = write_enable_i & ~illegal_o & (operation_i != OpNone) & ~trap_i & ~mret_i;

    // Next-state: trap > mret > CSR write
    always_comb begin
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        status_mpp_d  = status_mpp_q;
        priv_d        = priv_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        if (trap_i) begin
            mepc_d        = pc_i & AlignMask;
            mcause_d      = cause_i;
            mtval_d       = tval_i;
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
            status_mpp_d  = priv_q;
            priv_d        = PrivMachine;
        end else if (mret_i) begin
            status_mie_d  = status_mpie_q;
            status_mpie_d = 1'b1;
            priv_d        = status_mpp_q;
            status_mpp_d  = PrivUser;
        end else if (csr_we) begin
            case (address_i)
                CsrMstatus: begin
                    status_mie_d  = csr_wdata[MstatusMieBit];
                    status_mpie_d = csr_wdata[MstatusMpieBit];
                    // Only U and M exist; the reserved encodings collapse to U
                    status_mpp_d  = (csr_wdata[MstatusMppHi:MstatusMppLo] == 2'b11) ?
                                    PrivMachine : PrivUser;
                end
                CsrMie:      mie_d      = csr_wdata & MieWritableMask;
                CsrMtvec:    mtvec_d    = csr_wdata & AlignMask;
                CsrMscratch: mscratch_d = csr_wdata;
                CsrMepc:     mepc_d     = csr_wdata & AlignMask;
                CsrMcause:   mcause_d   = csr_wdata;
                CsrMtval:    mtval_d    = csr_wdata;
                default:     ;
            endcase
        end
    end

    // CSR and privilege state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            status_mpp_q  <= PrivUser;
            priv_q        <= PrivMachine;
            mie_q         <= 32'd0;
            mtvec_q       <= MTVEC_RESET;
            mscratch_q    <= 32'd0;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
            mtval_q       <= 32'd0;
        end else begin
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            status_mpp_q  <= status_mpp_d;
            priv_q        <= priv_d;
            mie_q         <= mie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && (address_i == CsrMcycle)),
        .wr_hi_i (csr_we && (address_i == CsrMcycleh)),
        .wdata_i (csr_wdata),
        .count_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (instret_i),
        .wr_lo_i (csr_we && (address_i == CsrMinstret)),
        .wr_hi_i (csr_we && (address_i == CsrMinstreth)),
        .wdata_i (csr_wdata),
        .count_o (minstret)
    );
`endif

    assign privilege_o = priv_q;
    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;

    // User mode always has interrupts globally enabled from M-mode's point of view
    assign interrupt_pending_o = (status_mie_q | (priv_q == PrivUser)) & |(mip_value & mie_q);

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Machine-mode CSR storage stage, directly downstream of the CSR decode unit.
- Consumes the decoded read enable, write enable, operation (WRITE/SET/CLEAR/NONE), 12-bit address and operand.
- Returns read data, flags unimplemented addresses, and keeps trap state, privilege level and the cycle/instret counters.
- Feeds the writeback stage, the fetch redirect logic and the interrupt controller.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- MISA_VALUE, 32'h4000_0100, constant returned by misa (RV32I).
- MHARTID, 32'h0, constant returned by mhartid.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset, asynchronous, active-low.
- read_enable_i  in  1  CSR read request.
- write_enable_i  in  1  CSR write request.
- operation_i  in  csrOperation_e  WRITE/SET/CLEAR/NONE.
- address_i  in  12  CSR address.
- data_i  in  32  write operand.
- trap_i  in  1  take a trap this cycle.
- mret_i  in  1  MRET retiring this cycle.
- cause_i  in  32  mcause value for the trap.
- pc_i  in  32  PC of the trapping instruction.
- tval_i  in  32  mtval value for the trap.
- instret_i  in  1  one instruction retired.
- irq_ext_i, irq_timer_i, irq_sw_i  in  1 each  interrupt lines.
- rdata_o  out  32  read data.
- illegal_o  out  1  unimplemented address accessed.
- privilege_o  out  privilegeLevel_e  current privilege.
- mtvec_o  out  32  trap vector base.
- mepc_o  out  32  return address.
- interrupt_pending_o  out  1  enabled interrupt pending.

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-low.
- Reset values:
  - mstatus, mie, mscratch, mepc, mcause, mtval = 0.
  - mtvec = MTVEC_RESET.
  - counters = 0.
  - privilege = MACHINE.
  - All outputs derived from these registers.
- Reads: combinational, same cycle. rdata_o = selected register when read_enable_i, else 0.
- Writes: registered at the next rising edge. New value by operation:
  - WRITE: data.
  - SET: old | data.
  - CLEAR: old & ~data.
  - NONE: no change.
- Writable-bit masks:
  - mstatus: only MIE[3], MPIE[7], MPP[12:11] writable. An MPP write of value 01 or 10 stores USER.
  - mtvec: bits [1:0] forced 00 (direct mode only).
  - mepc: bits [1:0] forced 00.
  - mie: bits 3, 7, 11 only.
  - mip: read-only; bit 11 = irq_ext_i, bit 7 = irq_timer_i, bit 3 = irq_sw_i.
- Constant registers: misa, mvendorid (0), marchid (0), mimpid (0), mhartid. Reads are legal, writes are ignored.
- Illegal access:
  - illegal_o = (read_enable_i | write_enable_i) & address not implemented. Combinational.
  - When illegal_o is high the write is suppressed.
- Trap entry (trap_i), at the edge:
  - mepc <= pc_i & ~3; mcause <= cause_i; mtval <= tval_i.
  - MPIE <= MIE; MIE <= 0; MPP <= privilege; privilege <= MACHINE.
- MRET (mret_i): MIE <= MPIE; MPIE <= 1; privilege <= MPP; MPP <= USER.
- Same-cycle priority: trap_i > mret_i > CSR write. A lower-priority event in the same cycle is dropped entirely.
- interrupt_pending_o = mstatus.MIE & |(mip & mie). In USER privilege the MIE gate is treated as 1.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle (0xB00/0xB80) increments every cycle.
  - 64-bit minstret (0xB02/0xB82) increments when instret_i.
  - Read-only shadows cycle/cycleh/instret/instreth at 0xC00/0xC80/0xC02/0xC82.
  - A CSR write to either half wins over that cycle's increment for that half. The other half still takes any carry.
  - The carry from the low to the high half is the full 64-bit add; 0xFFFF_FFFF wraps to 0 and increments the high half.
- Not defined: all eight addresses are unimplemented and raise illegal_o; no counter flops.

Decomposition:
- my_pkg holds:
  - csrOperation_e and privilegeLevel_e (existing).
  - New csrAddr_e enum of all addresses above.
  - mstatus bit-position constants and the mie/mip bit constants.
- Sub-module csr_counter64: 64-bit counter with increment enable and separate low/high write enables. Instantiated twice under CSR_COUNTERS_EN.

Test Plan:
- Reset, then read mtvec with MTVEC_RESET=32'h100 -> rdata_o=32'h100, privilege_o=MACHINE, illegal_o=0.
- mscratch: WRITE 32'hF0F0_0000, SET 32'h0000_000F, CLEAR 32'hF000_0000 -> reads return F0F0_0000, F0F0_000F, 00F0_000F.
- Set MIE=1 in USER privilege, then trap_i with pc_i=32'h1003, cause_i=32'h2 in the same cycle as a CSR write to mepc -> mepc=32'h1000, mcause=2, MIE=0, MPIE=1, MPP=USER, privilege=MACHINE, CSR write dropped.
- mret_i after the trap -> privilege=USER, MIE=1, MPIE=1, MPP=USER.
- Read 0x7C0 -> illegal_o=1, rdata_o=0. Write 0x7C0 -> illegal_o=1, no register changes.
- CSR_COUNTERS_EN: write mcycle=32'hFFFF_FFFE, mcycleh=0 -> after 2 cycles mcycle=0, mcycleh=1. Without the macro, read 0xB00 -> illegal_o=1.
